// File: rtl/i2c_cfg_sequencer.sv
// Power-up configuration sequencer: walks a register-init ROM and issues one
// 16-bit I2C register write per entry, with NACK retry and inter-write gap.
module i2c_cfg_sequencer #(
  parameter int         N_REGS     = 10,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 16,
  parameter int         IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic             s_CLK,
  input  logic             s_NRESET,
  input  logic             s_EN,
  output logic [IDX_W-1:0] o_ROM_ADDR,
  input  logic [15:0]      i_ROM_DATA,
  output logic             o_TX_VALID,
  input  logic             i_TX_READY,
  output logic [6:0]       o_TX_DEV,
  output logic [15:0]      o_TX_WORD,
  input  logic             i_TX_DONE,
  input  logic             i_TX_NACK,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_ERROR,
  output logic [IDX_W-1:0] o_ERR_IDX
);

  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic             HAS_GAP  = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic [2:0]       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [RTY_W-1:0] retry_q,   retry_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [15:0]      word_q,    word_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic             rtry_pq,   rtry_pd;
  logic             abort_q,   abort_d;

  // Next-state logic for the sequencer FSM and its counters.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    word_d    = word_q;
    err_idx_d = err_idx_q;
    rtry_pd   = rtry_pq;
    abort_d   = abort_q;
    case (state_q)
      S_IDLE: begin
        idx_d   = {IDX_W{1'b0}};
        retry_d = {RTY_W{1'b0}};
        abort_d = 1'b0;
        if (s_EN) state_d = S_FETCH;
        else      state_d = S_IDLE;
      end
      S_FETCH: begin
        if (!s_EN) state_d = S_IDLE;
        else       state_d = S_LATCH;
      end
      S_LATCH: begin
        if (!s_EN) begin
          state_d = S_IDLE;
        end else begin
          word_d  = i_ROM_DATA;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A request accepted in the same cycle EN falls is already owned by the engine.
        if (i_TX_READY) begin
          state_d = S_WAIT;
          abort_d = ~s_EN;
        end else if (!s_EN) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (!s_EN) abort_d = 1'b1;
        else       abort_d = abort_q;
        if (!i_TX_DONE) begin
          state_d = S_WAIT;
        end else if (abort_q || !s_EN) begin
          state_d = S_IDLE;
        end else if (!i_TX_NACK) begin
          retry_d = {RTY_W{1'b0}};
          rtry_pd = 1'b0;
          gap_d   = {GAP_W{1'b0}};
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else if (HAS_GAP) begin
            state_d = S_GAP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end
        end else if ((retry_q + RTY_W'(1)) == RTY_MAX) begin
          err_idx_d = idx_q;
          state_d   = S_ERROR;
        end else begin
          retry_d = retry_q + RTY_W'(1);
          rtry_pd = 1'b1;
          gap_d   = {GAP_W{1'b0}};
          if (HAS_GAP) state_d = S_GAP;
          else         state_d = S_ISSUE;
        end
      end
      S_GAP: begin
        if (!s_EN) begin
          state_d = S_IDLE;
        end else if (gap_q != GAP_MAX) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (rtry_pq) begin
          state_d = S_ISSUE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (!s_EN) state_d = S_IDLE;
        else       state_d = S_DONE;
      end
      S_ERROR: begin
        if (!s_EN) state_d = S_IDLE;
        else       state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge s_CLK or negedge s_NRESET) begin
    if (!s_NRESET) begin
      state_q   <= S_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      retry_q   <= {RTY_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      word_q    <= 16'h0000;
      err_idx_q <= {IDX_W{1'b0}};
      rtry_pq   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
      word_q    <= word_d;
      err_idx_q <= err_idx_d;
      rtry_pq   <= rtry_pd;
      abort_q   <= abort_d;
    end
  end

  assign o_ROM_ADDR = idx_q;
  assign o_TX_WORD  = word_q;
  assign o_TX_DEV   = DEV_ADDR;
  assign o_ERR_IDX  = err_idx_q;
  assign o_TX_VALID = (state_q == S_ISSUE);
  assign o_DONE     = (state_q == S_DONE);
  assign o_ERROR    = (state_q == S_ERROR);
  assign o_BUSY     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: ROM model, I2C engine model with
// scripted NACKs, scenario table plus hand-written corner-case sequences.
module tb_i2c_cfg_sequencer;

  localparam int N    = 4;
  localparam int MAXR = 2;
  localparam int GAP  = 4;
  localparam int DLAT = 20;

  logic        s_CLK, s_NRESET, s_EN;
  logic [1:0]  o_ROM_ADDR;
  logic [15:0] i_ROM_DATA;
  logic        o_TX_VALID, i_TX_READY;
  logic [6:0]  o_TX_DEV;
  logic [15:0] o_TX_WORD;
  logic        i_TX_DONE, i_TX_NACK;
  logic        o_BUSY, o_DONE, o_ERROR;
  logic [1:0]  o_ERR_IDX;

  i2c_cfg_sequencer #(
    .N_REGS(N), .DEV_ADDR(7'h1A), .MAX_RETRY(MAXR), .GAP_CYCLES(GAP)
  ) dut (
    .s_CLK(s_CLK), .s_NRESET(s_NRESET), .s_EN(s_EN),
    .o_ROM_ADDR(o_ROM_ADDR), .i_ROM_DATA(i_ROM_DATA),
    .o_TX_VALID(o_TX_VALID), .i_TX_READY(i_TX_READY),
    .o_TX_DEV(o_TX_DEV), .o_TX_WORD(o_TX_WORD),
    .i_TX_DONE(i_TX_DONE), .i_TX_NACK(i_TX_NACK),
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR), .o_ERR_IDX(o_ERR_IDX)
  );

  logic [15:0] rom [0:3] = '{16'h0C1F, 16'h0E42, 16'h10A5, 16'h1301};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nack_entry = -1;
  int nack_left  = 0;
  logic [15:0] acc_w [$];
  int          acc_i [$];
  logic [15:0] exp_w [$];

  typedef struct {
    int         ne;
    int         nt;
    int         n_acc;
    logic       done;
    logic       err;
    logic [1:0] err_idx;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    s_CLK = 1'b0;
    forever #5 s_CLK = ~s_CLK;
  end

  initial forever begin
    @(posedge s_CLK);
    cyc++;
  end

  // Synchronous ROM: address sampled at the edge, data valid the following cycle.
  initial begin
    logic [1:0] a;
    i_ROM_DATA = 16'h0000;
    forever begin
      @(posedge s_CLK);
      a = o_ROM_ADDR;
      #1 i_ROM_DATA = rom[a];
    end
  end

  // I2C engine model: accepts when ready, pulses done DLAT cycles later, checks gaps.
  initial begin
    int cnt, done_cyc;
    bit nk, have_done, last_nack, prev_valid, chk_drop;
    cnt = 0; done_cyc = 0; nk = 0; have_done = 0; last_nack = 0; prev_valid = 0; chk_drop = 0;
    i_TX_DONE = 1'b0;
    i_TX_NACK = 1'b0;
    forever begin
      @(negedge s_CLK);
      #2;
      i_TX_DONE = 1'b0;
      i_TX_NACK = 1'b0;
      if (!s_NRESET || !s_EN) have_done = 0;
      if (!s_NRESET) begin
        cnt = 0;
        chk_drop = 0;
      end
      if (chk_drop) begin
        chk("valid_drop_after_accept", 32'(o_TX_VALID), 32'd0);
        chk_drop = 0;
      end
      if (s_NRESET && o_TX_VALID && !prev_valid && have_done) begin
        chk(last_nack ? "retry_gap_latency" : "normal_gap_latency",
            32'(cyc - (done_cyc + 1)), last_nack ? 32'(GAP + 1) : 32'(GAP + 3));
        have_done = 0;
      end
      prev_valid = o_TX_VALID;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_TX_DONE = 1'b1;
          i_TX_NACK = nk;
          done_cyc  = cyc;
          last_nack = nk;
          have_done = 1;
        end
      end
      if (s_NRESET && o_TX_VALID && i_TX_READY) begin
        acc_w.push_back(o_TX_WORD);
        acc_i.push_back(int'(o_ROM_ADDR));
        cnt = DLAT;
        nk  = (int'(o_ROM_ADDR) == nack_entry) && (nack_left > 0);
        if (nk) nack_left--;
        chk_drop = 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge s_CLK);
  endtask

  task automatic do_reset();
    s_EN = 1'b0;
    s_NRESET = 1'b0;
    tick(2);
    s_NRESET = 1'b1;
    tick(1);
  endtask

  task automatic wait_term(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (o_DONE || o_ERROR) break;
      tick(1);
    end
    chk(name, 32'(o_DONE || o_ERROR), 32'd1);
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (acc_w.size() >= n) break;
      tick(1);
    end
    chk(name, 32'(acc_w.size() >= n), 32'd1);
  endtask

  // Expected word stream: each entry once, the NACKed entry repeated up to MAXR attempts.
  task automatic build_exp(input int ne, input int nt);
    int att;
    exp_w.delete();
    for (int i = 0; i < N; i++) begin
      att = (i == ne) ? ((nt + 1 < MAXR) ? nt + 1 : MAXR) : 1;
      for (int r = 0; r < att; r++) exp_w.push_back(rom[i]);
      if (i == ne && nt >= MAXR) break;
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{-1,  0, 4, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{ 2,  1, 5, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{ 1, 99, 3, 1'b0, 1'b1, 2'd1};
    tbl[3] = '{ 3,  1, 5, 1'b1, 1'b0, 2'd0};
    tbl[4] = '{ 0, 99, 2, 1'b0, 1'b1, 2'd0};
    tbl[5] = '{ 3, 99, 5, 1'b0, 1'b1, 2'd3};

    s_NRESET = 1'b0;
    s_EN = 1'b0;
    i_TX_READY = 1'b1;
    #12;
    chk("reset_state",
        {1'b0, o_TX_VALID, o_BUSY, o_DONE, o_ERROR, o_TX_WORD, o_ROM_ADDR, o_ERR_IDX, o_TX_DEV},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 7'h1A});

    for (int s = 0; s < 6; s++) begin
      do_reset();
      acc_w.delete();
      acc_i.delete();
      nack_entry = tbl[s].ne;
      nack_left  = tbl[s].nt;
      i_TX_READY = 1'b1;
      s_EN = 1'b1;
      wait_term(2000, $sformatf("s%0d_terminates", s));
      tick(40);
      build_exp(tbl[s].ne, tbl[s].nt);
      chk($sformatf("s%0d_accept_count", s), 32'(acc_w.size()), 32'(tbl[s].n_acc));
      for (int k = 0; k < exp_w.size() && k < acc_w.size(); k++)
        chk($sformatf("s%0d_word%0d", s, k), 32'(acc_w[k]), 32'(exp_w[k]));
      chk($sformatf("s%0d_done", s), 32'(o_DONE), 32'(tbl[s].done));
      chk($sformatf("s%0d_error", s), 32'(o_ERROR), 32'(tbl[s].err));
      chk($sformatf("s%0d_busy_valid", s), {30'd0, o_BUSY, o_TX_VALID}, 32'd0);
      if (tbl[s].err) chk($sformatf("s%0d_err_idx", s), 32'(o_ERR_IDX), 32'(tbl[s].err_idx));
      else            chk($sformatf("s%0d_dev", s), 32'(o_TX_DEV), 32'h1A);
      s_EN = 1'b0;
      tick(1);
      chk($sformatf("s%0d_flags_clear", s), {29'd0, o_DONE, o_ERROR, o_BUSY}, 32'd0);
    end

    // EN-to-VALID latency, then ready held low for 50 cycles.
    do_reset();
    acc_w.delete();
    acc_i.delete();
    nack_entry = -1;
    i_TX_READY = 1'b0;
    s_EN = 1'b1;
    n = 0;
    while (!o_TX_VALID && n < 10) begin
      tick(1);
      n++;
    end
    chk("en_to_valid_latency", 32'(n), 32'd3);
    for (int k = 0; k < 50; k++) begin
      tick(1);
      chk("valid_held_word_stable", {15'd0, o_TX_VALID, o_TX_WORD}, {15'd0, 1'b1, rom[0]});
    end
    i_TX_READY = 1'b1;
    tick(1);
    chk("accept_first_ready", 32'(acc_w.size()), 32'd1);
    tick(1);
    chk("valid_low_after_accept", 32'(o_TX_VALID), 32'd0);

    // EN dropped while waiting on entry 1: finish it, then idle.
    wait_acc(2, 200, "entry1_accepted");
    tick(3);
    s_EN = 1'b0;
    tick(2);
    chk("busy_during_abort_wait", 32'(o_BUSY), 32'd1);
    tick(40);
    chk("abort_no_new_request", 32'(acc_w.size()), 32'd2);
    chk("abort_idle", {28'd0, o_BUSY, o_DONE, o_TX_VALID, 1'b0}, 32'd0);
    chk("abort_rom_addr", 32'(o_ROM_ADDR), 32'd0);
    s_EN = 1'b1;
    wait_acc(3, 200, "restart_accepted");
    chk("restart_word", 32'(acc_w[2]), 32'(rom[0]));
    chk("restart_idx", 32'(acc_i[2]), 32'd0);

    // Reset pulsed during ISSUE.
    do_reset();
    i_TX_READY = 1'b0;
    s_EN = 1'b1;
    tick(4);
    chk("issue_before_reset", 32'(o_TX_VALID), 32'd1);
    #3 s_NRESET = 1'b0;
    #1;
    chk("reset_async_drop",
        {9'd0, o_TX_VALID, o_BUSY, o_DONE, o_ERROR, o_TX_WORD, o_ROM_ADDR, o_ERR_IDX},
        {9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0});
    @(negedge s_CLK);
    acc_w.delete();
    acc_i.delete();
    s_NRESET = 1'b1;
    i_TX_READY = 1'b1;
    wait_term(2000, "post_reset_terminates");
    tick(5);
    chk("post_reset_count", 32'(acc_w.size()), 32'd4);
    if (acc_w.size() > 0) chk("post_reset_first_word", 32'(acc_w[0]), 32'(rom[0]));
    else                  chk("post_reset_first_word", 32'(acc_w.size()), 32'd1);
    chk("post_reset_done", 32'(o_DONE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
# i2c_cfg_sequencer

Sequences the power-up configuration of the audio codec over I2C. The block walks a synchronous register-init ROM and issues one 16-bit register write per entry to the byte-level I2C master engine through a valid/ready/done handshake. It handles NACK retries and inter-transaction gaps, and reports done/error status to the top-level reset/enable logic.

## Interface
- N_REGS, 10: number of ROM entries to write (≥1).
- DEV_ADDR, 7'h1A: 7-bit codec slave address, driven constant on o_TX_DEV.
- MAX_RETRY, 3: transaction attempts per entry before declaring error (≥1).
- GAP_CYCLES, 16: idle s_CLK cycles after each completed transaction (0 = no gap).
- IDX_W, $clog2(N_REGS) (min 1): index/ROM address width.

Ports:
- s_CLK  in  1  system clock.
- s_NRESET  in  1  reset, asynchronous, active-low.
- s_EN  in  1  level enable; rising into IDLE starts a sequence.
- o_ROM_ADDR  out  IDX_W  current entry index to ROM.
- i_ROM_DATA  in  16  ROM word: [15:9] register address, [8:0] data; valid the cycle after the address is sampled.
- o_TX_VALID  out  1  transaction request to I2C engine.
- i_TX_READY  in  1  engine accepts request when high with o_TX_VALID.
- o_TX_DEV  out  7  slave address (= DEV_ADDR).
- o_TX_WORD  out  16  word to transmit, MSB first.
- i_TX_DONE  in  1  one-cycle pulse: transaction finished.
- i_TX_NACK  in  1  qualified by i_TX_DONE: a NACK occurred.
- o_BUSY  out  1  sequence in progress.
- o_DONE  out  1  all N_REGS entries written.
- o_ERROR  out  1  entry failed MAX_RETRY times.
- o_ERR_IDX  out  IDX_W  index of failing entry.

## Operation
- States: IDLE, FETCH, LATCH, ISSUE, WAIT, GAP, DONE, ERROR.
- IDLE: idx=0, retry=0. s_EN=1 → FETCH. o_BUSY=1 in all states except IDLE, DONE and ERROR.
- FETCH: o_ROM_ADDR=idx; 1 cycle → LATCH.
- LATCH: o_TX_WORD ← i_ROM_DATA; → ISSUE.
- ISSUE: o_TX_VALID=1. o_TX_WORD and o_TX_DEV stay stable until accept. On o_TX_VALID & i_TX_READY → WAIT.
- WAIT: i_TX_DONE & ~i_TX_NACK → retry=0, then:
  - last entry (idx==N_REGS-1) → DONE;
  - GAP_CYCLES>0 → GAP;
  - otherwise idx+1 → FETCH.
- WAIT: i_TX_DONE & i_TX_NACK → retry+1.
  - retry+1 == MAX_RETRY → ERROR, o_ERR_IDX=idx.
  - otherwise → GAP (if GAP_CYCLES>0), then back to ISSUE with the same word. No refetch.
- GAP: counts GAP_CYCLES cycles, then → FETCH (idx+1) or ISSUE (retry path).
- DONE: o_DONE=1. ERROR: o_ERROR=1. Both hold until s_EN=0, then → IDLE and the flag clears.
- s_EN=0 handling:
  - in FETCH, LATCH, ISSUE (before accept) or GAP → IDLE next edge; o_TX_VALID drops.
  - in WAIT → finish the transaction, ignore its result, → IDLE.
- i_TX_DONE outside WAIT is ignored.
- Counters: retry width $clog2(MAX_RETRY+1); gap width $clog2(GAP_CYCLES+1). No wrap: idx never exceeds N_REGS-1.

## Timing
- Reset (async assert, sync deassert upstream): state=IDLE. All outputs 0 except o_TX_DEV=DEV_ADDR. o_TX_WORD=0, o_ROM_ADDR=0, o_ERR_IDX=0.
- All outputs are registered or decoded from registered state. No combinational path from i_TX_READY/i_TX_DONE to outputs.
- Latency:
  - EN sampled high at edge k → o_TX_VALID high after edge k+2.
  - Accept at edge a → o_TX_VALID low after edge a.
  - Done at edge d → next o_TX_VALID after edge d+GAP_CYCLES+3 (normal path) or d+GAP_CYCLES+1 (retry path).
- Accept and done pulses are never combined in the same cycle; the engine guarantees i_TX_DONE ≥1 cycle after accept.
- Reset mid-transaction: immediate return to IDLE; o_TX_VALID falls asynchronously.

## Test plan
- N_REGS=4, GAP=4, engine model always ready, done 20 cycles after accept, no NACK, EN=1 → four accepts with words ROM[0..3] in order. o_DONE rises after the 4th done; o_BUSY=0; o_ERROR=0.
- Engine NACKs entry 2 once (MAX_RETRY=3) → entry 2 is sent twice with an identical word, the sequence completes, o_DONE=1.
- Engine NACKs entry 1 always, MAX_RETRY=2 → exactly 2 attempts, o_ERROR=1, o_ERR_IDX=1, no request for entry 2. EN=0 → IDLE, o_ERROR=0.
- i_TX_READY held low 50 cycles → o_TX_VALID held and o_TX_WORD stable for 50 cycles; accept on the first ready cycle.
- EN dropped in WAIT of entry 1 → no new o_TX_VALID after that done. State is IDLE, o_DONE=0. Re-raising EN restarts at entry 0.
- s_NRESET pulsed low during ISSUE → o_TX_VALID=0 immediately, all flags 0. After release with EN=1, the sequence restarts from entry 0.
